conv_window_fetcher: RTL and testbench

- Reads a row-major feature map from the single-port image Buffer and emits K x K convolution windows, one per output position, to the convolution PE.
- Sits directly downstream of the Buffer.
  - Drives the Buffer's address port.
  - Samples its combinational read data the same cycle.
- Stride 1. Windows are emitted in raster order with a valid/ready handshake. A start/done pair delimits each frame.

---
 rtl/conv_window_fetcher.sv | 178 +++++++++++++++++
 tb/tb_conv_window_fetcher.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_fetcher.sv
// conv_window_fetcher
//   Walks a row-major IMG_W x IMG_H feature map held in a single-port Buffer
//   and presents one K x K window per output position (stride 1, raster
//   order) on a valid/ready interface. Buffer read data is combinational and
//   is captured into the window in the same cycle the address is driven.
//
//   Optional build macro: CONV_WINDOW_ZERO_PAD_EN
//     defined   -> "same" zero padding, output grid equals the image grid
//     undefined -> no padding, output grid (IMG_W-K+1) x (IMG_H-K+1)
//
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   start       begin one frame (sampled only while idle)
//   busy        high whenever the fetcher is not idle
//   done        one-cycle pulse after the last window handshake
//   buf_adr     Buffer read address (held outside fetch, 0 after reset)
//   buf_data    Buffer read data, valid the same cycle as buf_adr
//   win_valid   win_data holds a complete window
//   win_ready   consumer accepts the window
//   win_data    tap (r,c) at bits [(r*K+c)*WORD_SIZE +: WORD_SIZE]
//   win_row     output-position row of the current window
//   win_col     output-position column of the current window
module conv_window_fetcher #(
  parameter int WORD_SIZE = 8,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int K         = 5,
  localparam int ADR_SIZE = $clog2(IMG_W*IMG_H),
  localparam int RW       = $clog2(IMG_H),
  localparam int CW       = $clog2(IMG_W)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [ADR_SIZE-1:0]      buf_adr,
  input  logic [WORD_SIZE-1:0]     buf_data,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic [K*K*WORD_SIZE-1:0] win_data,
  output logic [RW-1:0]            win_row,
  output logic [CW-1:0]            win_col
);

  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int TW = (K > 1) ? $clog2(K*K) : 1;
`ifdef CONV_WINDOW_ZERO_PAD_EN
  localparam int P     = (K - 1) / 2;
  localparam int OUT_W = IMG_W;
  localparam int OUT_H = IMG_H;
`else
  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [RW-1:0]         wr_q;
  logic [CW-1:0]         wc_q;
  logic [KW-1:0]         tr_q, tc_q;
  logic [TW-1:0]         t_q;
  logic [ADR_SIZE-1:0]   adr_q;
  logic [WORD_SIZE-1:0]  taps_q [K*K];

  logic [ADR_SIZE-1:0]   fetch_adr;
  logic [WORD_SIZE-1:0]  tap_pix;
  logic                  last_tap, last_win;

  assign last_tap = (tr_q == KW'(K-1)) && (tc_q == KW'(K-1));
  assign last_win = (wr_q == RW'(OUT_H-1)) && (wc_q == CW'(OUT_W-1));

  // Address of the current tap; arithmetic is one bit wider than the
  // address bus and truncated afterwards.
`ifdef CONV_WINDOW_ZERO_PAD_EN
  logic signed [31:0] pr, pc;
  logic               oob;

  always_comb begin
    pr  = int'(wr_q) + int'(tr_q) - P;
    pc  = int'(wc_q) + int'(tc_q) - P;
    oob = (pr < 0) || (pr >= IMG_H) || (pc < 0) || (pc >= IMG_W);
    if (oob) begin
      fetch_adr = '0;
      tap_pix   = '0;
    end else begin
      fetch_adr = ADR_SIZE'((ADR_SIZE+1)'(pr) * (ADR_SIZE+1)'(IMG_W)
                            + (ADR_SIZE+1)'(pc));
      tap_pix   = buf_data;
    end
  end
`else
  always_comb begin
    fetch_adr = ADR_SIZE'(((ADR_SIZE+1)'(wr_q) + (ADR_SIZE+1)'(tr_q))
                          * (ADR_SIZE+1)'(IMG_W)
                          + (ADR_SIZE+1)'(wc_q) + (ADR_SIZE+1)'(tc_q));
    tap_pix   = buf_data;
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: if (last_tap) state_d = S_HOLD;
      S_HOLD:  if (win_ready) state_d = last_win ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wr_q    <= '0;
      wc_q    <= '0;
      tr_q    <= '0;
      tc_q    <= '0;
      t_q     <= '0;
      adr_q   <= '0;
      for (int unsigned i = 0; i < K*K; i++) taps_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            wr_q <= '0;
            wc_q <= '0;
            tr_q <= '0;
            tc_q <= '0;
            t_q  <= '0;
          end
        end
        S_FETCH: begin
          taps_q[t_q] <= tap_pix;
          adr_q       <= fetch_adr;
          t_q         <= last_tap ? '0 : t_q + 1'b1;
          if (tc_q == KW'(K-1)) begin
            tc_q <= '0;
            tr_q <= last_tap ? '0 : tr_q + 1'b1;
          end else begin
            tc_q <= tc_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (win_ready && !last_win) begin
            if (wc_q == CW'(OUT_W-1)) begin
              wc_q <= '0;
              wr_q <= wr_q + 1'b1;
            end else begin
              wc_q <= wc_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < K*K; g++) begin : g_pack
    assign win_data[g*WORD_SIZE +: WORD_SIZE] = taps_q[g];
  end

  // Live address while fetching, otherwise the last address fetched.
  assign buf_adr   = (state_q == S_FETCH) ? fetch_adr : adr_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign win_valid = (state_q == S_HOLD);
  assign win_row   = wr_q;
  assign win_col   = wc_q;

endmodule

// File: tb/tb_conv_window_fetcher.sv
// Bench for conv_window_fetcher with IMG_W=IMG_H=4, K=3 and a Buffer model
// holding mem[a]=a. Latencies are counted in rising edges after the edge
// that samples start.
module tb_conv_window_fetcher;

  logic        clk = 1'b0;
  logic        rst_n, start, win_ready;
  logic        busy, done, win_valid;
  logic [3:0]  buf_adr;
  logic [7:0]  buf_data;
  logic [71:0] win_data;
  logic [1:0]  win_row, win_col;
  logic [7:0]  mem [16];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int hs_cnt = 0;

  typedef struct {
    int          row;
    int          col;
    int          lat;
    logic [3:0]  adr;
    logic [71:0] data;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  assign buf_data = mem[buf_adr];

  conv_window_fetcher #(
    .WORD_SIZE(8),
    .IMG_W(4),
    .IMG_H(4),
    .K(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .busy(busy),
    .done(done),
    .buf_adr(buf_adr),
    .buf_data(buf_data),
    .win_valid(win_valid),
    .win_ready(win_ready),
    .win_data(win_data),
    .win_row(win_row),
    .win_col(win_col)
  );

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (win_valid && win_ready) hs_cnt++;
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_now();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs a 4-window frame already started. bp_win/bp_len: window held under
  // backpressure (bp_win<0 for none). poke: pulse start during FETCH, during
  // HOLD and in the done cycle, all of which must be ignored.
  task automatic run_frame(input int bp_win, input int bp_len, input bit poke);
    int n, k, hs0, dn0, shift;
    n = 0; hs0 = hs_cnt; dn0 = done_cnt;
    for (int w = 0; w < 4; w++) begin
      k = 0;
      while (!win_valid && k < 40) begin
        @(posedge clk); #1; n++; k++;
        start = poke && (w == 0) && (n == 3);
        if (w == 0 && n == 3) check("fetch_adr", buf_adr, 4);
      end
      start = 1'b0;
      shift = (bp_win >= 0 && w > bp_win) ? bp_len : 0;
      check("win_valid", win_valid, 1);
      check("latency", n, vecs[w].lat + shift);
      check("win_row", win_row, vecs[w].row);
      check("win_col", win_col, vecs[w].col);
      check("win_data", win_data, vecs[w].data);
      check("hold_adr", buf_adr, vecs[w].adr);
      for (int d = 0; d < ((w == bp_win) ? bp_len : 0); d++) begin
        @(posedge clk); #1; n++;
        start = poke && (d == 2);
        check("bp_valid", win_valid, 1);
        check("bp_data", win_data, vecs[w].data);
        check("bp_row", win_row, vecs[w].row);
        check("bp_col", win_col, vecs[w].col);
      end
      start = 1'b0;
      win_ready = 1'b1;
      @(posedge clk); #1; n++;
      win_ready = 1'b0;
      if (w < 3) check("advance", win_valid, 0);
    end
    check("done", done, 1);
    check("done_lat", n, 40 + ((bp_win >= 0) ? bp_len : 0));
    start = poke;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_pulse", done, 0);
    check("busy_fall", busy, 0);
    check("hs_count", hs_cnt - hs0, 4);
    check("done_count", done_cnt - dn0, 1);
  endtask

`ifdef CONV_WINDOW_ZERO_PAD_EN
  task automatic run_pad();
    int n, k;
    logic [71:0] pad00, pad33;
    // tap 8 ... tap 0
    pad00 = {8'd5, 8'd4, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    pad33 = {8'd0, 8'd0, 8'd0, 8'd0, 8'd15, 8'd14, 8'd0, 8'd11, 8'd10};
    n = 0;
    for (int w = 0; w < 16; w++) begin
      k = 0;
      while (!win_valid && k < 40) begin
        @(posedge clk); #1; n++; k++;
      end
      check("pad_valid", win_valid, 1);
      check("pad_row", win_row, w / 4);
      check("pad_col", win_col, w % 4);
      if (w == 0)  check("pad_data00", win_data, pad00);
      if (w == 15) check("pad_data33", win_data, pad33);
      win_ready = 1'b1;
      @(posedge clk); #1; n++;
      win_ready = 1'b0;
    end
    check("pad_done", done, 1);
    check("pad_done_lat", n, 160);
  endtask
`endif

  initial begin
    int dn0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    // tap 8 ... tap 0
    vecs[0] = '{row: 0, col: 0, lat: 9,  adr: 4'd10,
                data: {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0}};
    vecs[1] = '{row: 0, col: 1, lat: 19, adr: 4'd11,
                data: {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1}};
    vecs[2] = '{row: 1, col: 0, lat: 29, adr: 4'd14,
                data: {8'd14, 8'd13, 8'd12, 8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4}};
    vecs[3] = '{row: 1, col: 1, lat: 39, adr: 4'd15,
                data: {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5}};

    rst_n = 1'b0; start = 1'b0; win_ready = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", win_valid, 0);
    check("rst_adr", buf_adr, 0);
    check("rst_data", win_data, 0);
    check("rst_row", win_row, 0);
    check("rst_col", win_col, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef CONV_WINDOW_ZERO_PAD_EN
    start_now();
    run_pad();
`else
    // basic frame
    start_now();
    run_frame(-1, 0, 1'b0);
    // back-to-back: start right after returning to idle
    start_now();
    run_frame(-1, 0, 1'b0);
    // backpressure on window (0,1) plus ignored start pulses
    start_now();
    run_frame(1, 6, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("idle_after_poke", busy, 0);

    // reset during fetch of window (1,0)
    win_ready = 1'b1;
    start_now();
    repeat (23) @(posedge clk);
    #1;
    check("mid_row", win_row, 1);
    check("mid_col", win_col, 0);
    check("mid_busy", busy, 1);
    check("mid_valid", win_valid, 0);
    dn0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", win_valid, 0);
    check("arst_done", done, 0);
    check("arst_adr", buf_adr, 0);
    check("arst_data", win_data, 0);
    check("arst_row", win_row, 0);
    check("arst_col", win_col, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    win_ready = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("no_done_after_rst", done_cnt - dn0, 0);
    check("idle_after_rst", busy, 0);
    start_now();
    run_frame(-1, 0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
